// File: rtl/conv2d_param_if.sv
// Stream bus for conv2d_param: filter/image words in, convolution results out.
interface conv2d_param_if #(
    parameter int DW = 6,
    parameter int OW = 16
);
    logic                 filter_valid;
    logic                 image_valid;
    logic                 pad_mode;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    modport master (
        output filter_valid, image_valid, pad_mode, in_data,
        input  out_valid, out_data, out_last, busy
    );

    modport slave (
        input  filter_valid, image_valid, pad_mode, in_data,
        output out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/conv2d_param.sv
// Parameterised 2-D convolution engine: loads a KxK filter and an NxN image,
// then streams the valid- or same-mode convolution one result per cycle.
module conv2d_param #(
    parameter int IMG_N = 7,
    parameter int KER_K = 3,
    parameter int DW    = 6
) (
    input logic           clk,
    input logic           rst_n,
    conv2d_param_if.slave bus
);
    localparam int OW  = 2*DW + $clog2(KER_K*KER_K);
    localparam int NK  = KER_K*KER_K;
    localparam int NP  = IMG_N*IMG_N;
    localparam int FW  = (NK > 1) ? $clog2(NK) : 1;
    localparam int PW  = (NP > 1) ? $clog2(NP) : 1;
    localparam int RW  = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int PAD = (KER_K-1)/2;

    typedef enum logic [1:0] {IDLE, LOAD_F, LOAD_I, OUT} state_t;

    state_t               state, state_n;
    logic signed [DW-1:0] coef [NK];
    logic signed [DW-1:0] img  [NP];
    logic [FW-1:0]        f_idx;
    logic [PW-1:0]        p_idx;
    logic [RW-1:0]        r_cnt, c_cnt, m_max;
    logic                 pad_q;
    logic                 f_we, i_we, pad_ld, run;
    logic                 pix_last, res_last;
    logic signed [OW-1:0] acc_p0;
    logic signed [OW-1:0] out_data_p1;
    logic                 vld_p1, last_p1, busy_q;

    function automatic logic signed [OW-1:0] sext(input logic signed [DW-1:0] v);
        return OW'(v);
    endfunction

    // Pixels outside the image read as zero so same mode needs no stored border.
    function automatic logic signed [OW-1:0] pix_at(input int rr, input int cc);
        logic [PW-1:0] idx;
        if (rr < 0 || rr >= IMG_N || cc < 0 || cc >= IMG_N)
            return '0;
        idx = PW'(rr*IMG_N + cc);
        return sext(img[idx]);
    endfunction

    assign pix_last = (p_idx == PW'(NP-1));
    assign m_max    = pad_q ? RW'(IMG_N-1) : RW'(IMG_N-KER_K);
    assign res_last = (r_cnt == m_max) && (c_cnt == m_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, LOAD_F: begin
                if (bus.filter_valid)     state_n = LOAD_F;
                else if (bus.image_valid) state_n = pix_last ? OUT : LOAD_I;
            end
            LOAD_I:  if (bus.image_valid && pix_last) state_n = OUT;
            OUT:     if (res_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Filter words win over image words while the filter may still be loading.
    always_comb begin
        f_we   = 1'b0;
        i_we   = 1'b0;
        pad_ld = 1'b0;
        run    = 1'b0;
        case (state)
            IDLE, LOAD_F: begin
                f_we   = bus.filter_valid;
                i_we   = bus.image_valid && !bus.filter_valid;
                pad_ld = i_we;
            end
            LOAD_I:  i_we = bus.image_valid;
            OUT:     run  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) coef[i] <= '0;
        end else if (f_we) begin
            coef[f_idx] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) img[p_idx] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_idx <= '0;
            p_idx <= '0;
            pad_q <= 1'b0;
            r_cnt <= '0;
            c_cnt <= '0;
        end else begin
            if (f_we)        f_idx <= (f_idx == FW'(NK-1)) ? '0 : f_idx + 1'b1;
            else if (pad_ld) f_idx <= '0;
            if (pad_ld) pad_q <= bus.pad_mode;
            if (i_we)   p_idx <= pix_last ? '0 : p_idx + 1'b1;
            if (run) begin
                if (c_cnt == m_max) begin
                    c_cnt <= '0;
                    r_cnt <= (r_cnt == m_max) ? '0 : r_cnt + 1'b1;
                end else begin
                    c_cnt <= c_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 0: full KxK multiply-accumulate for the current (r_cnt, c_cnt).
    always_comb begin
        int off;
        off    = pad_q ? PAD : 0;
        acc_p0 = '0;
        for (int ki = 0; ki < KER_K; ki++) begin
            for (int kj = 0; kj < KER_K; kj++) begin
                acc_p0 = acc_p0 + sext(coef[FW'(ki*KER_K + kj)]) *
                         pix_at(int'(r_cnt) + ki - off, int'(c_cnt) + kj - off);
            end
        end
    end

    // Stage 1: registered result, valid and frame-end flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_data_p1 <= run ? acc_p0 : '0;
            vld_p1      <= run;
            last_p1     <= run && res_last;
            busy_q      <= (state != IDLE) || f_we || i_we;
        end
    end

    assign bus.out_data  = out_data_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_last  = last_p1;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_conv2d_param.sv
// Directed scoreboard bench for conv2d_param at default parameters.
module tb_conv2d_param;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int data;
        bit last;
    } exp_t;
    exp_t exp_q[$];

    conv2d_param_if #(.DW(6), .OW(16)) bus ();

    conv2d_param #(.IMG_N(7), .KER_K(3), .DW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", longint'(bus.out_data), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(longint'(bus.out_data) == longint'(e.data), "result_data",
                        longint'(bus.out_data), longint'(e.data));
                    chk(bus.out_last === e.last, "result_last",
                        longint'(bus.out_last), longint'(e.last));
                end
            end
        end
    endtask

    task automatic put(input bit fv, input bit iv, input bit pm, input int d);
        bus.filter_valid = fv;
        bus.image_valid  = iv;
        bus.pad_mode     = pm;
        bus.in_data      = 6'(d);
        @(posedge clk);
        #1;
    endtask

    function automatic int coef_of(input int kind, input int i);
        case (kind)
            0:       return 1;
            1:       return -32;
            default: return i;
        endcase
    endfunction

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 1;
            1:       return -32;
            2:       return 31;
            3:       return r;
            4:       return r - c;
            default: return 7;
        endcase
    endfunction

    function automatic int win(input int x);
        return (x == 0 || x == 6) ? 2 : 3;
    endfunction

    function automatic int exp_val(input int t, input int r, input int c);
        case (t)
            0:       return 9;
            1:       return win(r) * win(c);
            2:       return 9216;
            3:       return -8928;
            4:       return 36*r + 54;
            5:       return 5*(r - c);
            default: return 0;
        endcase
    endfunction

    task automatic push_frame(input int t, input int m, input int limit);
        exp_t e;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++)
                if (r*m + c < limit) begin
                    e.data = exp_val(t, r, c);
                    e.last = (r == m-1) && (c == m-1) && (limit >= m*m);
                    exp_q.push_back(e);
                end
    endtask

    task automatic send_filter(input int kind);
        for (int i = 0; i < 9; i++) begin
            put(1'b1, 1'b0, 1'b0, coef_of(kind, i));
            if (i == 0) chk(bus.busy === 1'b1, "busy_on_load", longint'(bus.busy), 1);
        end
        bus.filter_valid = 1'b0;
    endtask

    task automatic send_image(input int kind, input bit pm, input int gap);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) begin
                put(1'b0, 1'b1, pm, pix_of(kind, r, c));
                if (!(r == 6 && c == 6))
                    repeat (gap) put(1'b0, 1'b0, 1'b0, 0);
            end
        bus.image_valid = 1'b0;
    endtask

    task automatic wait_frame(input int n_exp, input string nm);
        int cnt  = 0;
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (seen) begin
                chk(bus.busy === 1'b0, "busy_fall", longint'(bus.busy), 0);
                done = 1'b1;
            end else begin
                if (bus.out_valid === 1'b1) cnt++;
                if (bus.out_last === 1'b1) begin
                    seen = 1'b1;
                    chk(bus.busy === 1'b1, "busy_at_last", longint'(bus.busy), 1);
                end
            end
        end
        if (!done) chk(1'b0, {nm, "_timeout"}, 0, 1);
        chk(cnt == n_exp, {nm, "_count"}, cnt, n_exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.filter_valid = 1'b0;
        bus.image_valid  = 1'b0;
        bus.pad_mode     = 1'b0;
        bus.in_data      = '0;
        rst_n            = 1'b0;
        fork
            monitor_loop();
        join_none

        #12;
        chk(bus.out_valid === 1'b0, "rst_out_valid", longint'(bus.out_valid), 0);
        chk(bus.out_last === 1'b0, "rst_out_last", longint'(bus.out_last), 0);
        chk(bus.busy === 1'b0, "rst_busy", longint'(bus.busy), 0);
        chk(bus.out_data === 16'sd0, "rst_out_data", longint'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // A: ones filter, ones image, valid mode, with first-result latency
        push_frame(0, 5, 25);
        send_filter(0);
        send_image(0, 1'b0, 0);
        chk(bus.out_valid === 1'b0, "latency_early", longint'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        chk(bus.out_valid === 1'b1, "latency_first", longint'(bus.out_valid), 1);
        wait_frame(25, "frame_a");

        // B: filter reuse, same mode
        push_frame(1, 7, 49);
        send_image(0, 1'b1, 0);
        wait_frame(49, "frame_b");

        // C/D: extreme values
        push_frame(2, 5, 25);
        send_filter(1);
        send_image(1, 1'b0, 0);
        wait_frame(25, "frame_c");
        push_frame(3, 5, 25);
        send_image(2, 1'b0, 0);
        wait_frame(25, "frame_d");

        // E: ramp filter with row-index image, then the image alone again
        push_frame(4, 5, 25);
        send_filter(2);
        send_image(3, 1'b0, 0);
        wait_frame(25, "frame_e");
        push_frame(4, 5, 25);
        send_image(3, 1'b0, 0);
        wait_frame(25, "frame_e2");

        // F: both valids in IDLE take the filter path; gapped image
        push_frame(5, 5, 25);
        put(1'b1, 1'b1, 1'b0, 5);
        for (int i = 1; i < 9; i++) put(1'b1, 1'b0, 1'b0, 0);
        bus.filter_valid = 1'b0;
        send_image(4, 1'b0, 3);
        wait_frame(25, "frame_f");

        // G: asynchronous reset on the 10th result
        push_frame(5, 5, 10);
        send_image(4, 1'b0, 0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        chk(seen == 10, "reset_frame_outputs", seen, 10);
        #2 rst_n = 1'b0;
        #1;
        chk(bus.out_valid === 1'b0, "async_rst_valid", longint'(bus.out_valid), 0);
        chk(bus.busy === 1'b0, "async_rst_busy", longint'(bus.busy), 0);
        chk(bus.out_last === 1'b0, "async_rst_last", longint'(bus.out_last), 0);
        chk(exp_q.size() == 0, "reset_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // H: filter cleared by reset gives all-zero results
        push_frame(6, 5, 25);
        send_image(5, 1'b0, 0);
        wait_frame(25, "frame_h");

        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
